dma_arbiter: RTL and testbench
==============================

DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, DMA address width.
REQ-002 SHALL have parameter DATA_W, default 16, DMA data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, the most consecutive accesses per grant when another requester is waiting (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  3  per-requester request; index 0 = load block, 1 = pool layer, 2 = store/writeback.
REQ-007 SHALL have port req_rw  input  3  per-requester direction; 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  3*ADDR_W  per-requester address, packed, requester i in slice i.
REQ-009 SHALL have port req_wdata  input  3*DATA_W  per-requester write data, packed the same way.
REQ-010 SHALL have port gnt  output  3  one-hot registered grant.
REQ-011 SHALL have port ack  output  3  one-hot; high for the cycle in which the granted requester's access is issued to the DMA.
REQ-012 SHALL have port rvalid  output  3  one-hot; high one cycle after a read ack.
REQ-013 SHALL have port rdata  output  DATA_W  DMA read data, passed through to all requesters.
REQ-014 SHALL have ports dma_enable (output, 1), dma_rw (output, 1), dma_addr (output, ADDR_W), dma_wdata (output, DATA_W) and dma_rdata (input, DATA_W), forming the shared DMA port.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and GRANT.
REQ-016 In IDLE with any req high, SHALL choose the winner round-robin, starting at the index after last_owner, then set gnt and enter GRANT next cycle; dma_enable SHALL be 0 in IDLE.
REQ-017 In GRANT with req[owner] high, SHALL drive dma_enable=1, and route the owner's rw, addr and wdata combinationally to the dma_* outputs.
REQ-018 In GRANT with req[owner] high, SHALL drive ack[owner]=1 in the same cycle; the requester advances its address on ack.
REQ-019 In GRANT with req[owner] low, SHALL drive dma_enable=0 and ack=0, clear gnt, set last_owner=owner and return to IDLE; this costs one bubble cycle.
REQ-020 SHALL assert rvalid[owner] exactly one cycle after each read ack, with rdata = dma_rdata in that cycle; write acks produce no rvalid.
REQ-021 SHALL reset the burst counter (8-bit) to 0 on each new grant and increment it on every ack.
REQ-022 Burst limit: when the ack that brings the count to MAX_BURST occurs and another req is high, SHALL release to IDLE next cycle, setting last_owner=owner.
REQ-023 Burst limit with no other req high: SHALL set the counter to 0 and keep the grant.
REQ-024 req changes by non-owners during GRANT SHALL NOT affect dma_* outputs.
REQ-025 gnt, ack and rvalid SHALL each always be zero or one-hot.

Reset
REQ-026 While reset is high, SHALL force state=IDLE, gnt=0, last_owner=2 (so requester 0 wins the first tie), counter=0 and rvalid=0.
REQ-027 While reset is high, SHALL force ack=0, dma_enable=0, dma_rw=0, dma_addr=0, dma_wdata=0 and rdata=0.
REQ-028 Reset asserted mid-burst SHALL abort the grant, and no rvalid SHALL appear for a read acked in the reset cycle.

Configuration
REQ-029 With macro DMA_ARB_BURST_LIMIT_EN defined, SHALL enforce REQ-021..REQ-023.
REQ-030 Without DMA_ARB_BURST_LIMIT_EN, SHALL omit the burst counter and hold a grant until the owner drops req; MAX_BURST is then ignored.

Verification
REQ-031 Scenario: single read: req=001, addr=0x0005 for 1 cycle after grant -> gnt=001 at cycle 1, ack[0] and dma_addr=5 at cycle 1, rvalid[0]=1 with rdata=dma_rdata at cycle 2.
REQ-032 Scenario: req=111 held continuously, MAX_BURST=4, limit enabled -> grants rotate 0,1,2,0, each with exactly 4 acks followed by one idle cycle.
REQ-033 Scenario: req=010 write burst of 20 accesses with the limit enabled and no competitor -> 20 consecutive acks, gnt stays 010, no rvalid.
REQ-034 Scenario: the owner is 0 mid-burst and req[2] rises -> dma_addr stays on requester 0's address until release, then requester 2 is granted after one bubble cycle.
REQ-035 Scenario: reset pulsed for 1 cycle in GRANT during a read -> all outputs 0 next cycle, no rvalid, and requester 0 wins the next arbitration.
REQ-036 Scenario: limit disabled, req=011 held with MAX_BURST=4 -> requester 0 keeps the grant for all cycles until it drops req.

Source files
------------

// File: rtl/dma_arbiter.sv
// dma_arbiter: three-way round-robin arbiter in front of a single shared DMA port.
// Requesters: 0 = load block, 1 = pool layer, 2 = store/writeback.
// The owner's access is issued combinationally in the cycle it is acked, and
// read data is flagged with rvalid one cycle after a read ack.
// Optional feature macro: DMA_ARB_BURST_LIMIT_EN. When defined, a grant is
// released after MAX_BURST consecutive acks if another requester is waiting.
// When undefined, a grant is held until the owner drops its request.
module dma_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            req_rw,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            ack,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  dma_enable,
    output logic                  dma_rw,
    output logic [ADDR_W-1:0]     dma_addr,
    output logic [DATA_W-1:0]     dma_wdata,
    input  logic [DATA_W-1:0]     dma_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The burst counter is 8 bits wide, so the limit must fit in 1..255.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("dma_arbiter: MAX_BURST must be in 1..255");
    end

    state_t       state;
    logic [1:0]   owner;
    logic [1:0]   last_owner;
    logic [2:0]   gnt_q;
    logic [2:0]   rvalid_q;

    logic         owner_req;
    logic         owner_rw;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;
    logic [2:0]   owner_mask;
    logic         issue;
    logic         others_req;
    logic [1:0]   winner;

`ifdef DMA_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    logic [7:0]   burst_cnt;
`endif

    // Round-robin pick: search starts at the requester after the last owner.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (r[first])       return first;
        else if (r[second]) return second;
        else                return third;
    endfunction

    assign winner = rr_pick(req, last_owner);

    // Select the current owner's request, direction, address and write data.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        owner_req   = 1'b0;
        owner_rw    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        owner_mask  = 3'b000;
        case (owner)
            2'd0: begin
                owner_req   = req[0];
                owner_rw    = req_rw[0];
                owner_addr  = req_addr[0*ADDR_W +: ADDR_W];
                owner_wdata = req_wdata[0*DATA_W +: DATA_W];
                owner_mask  = 3'b001;
            end
            2'd1: begin
                owner_req   = req[1];
                owner_rw    = req_rw[1];
                owner_addr  = req_addr[1*ADDR_W +: ADDR_W];
                owner_wdata = req_wdata[1*DATA_W +: DATA_W];
                owner_mask  = 3'b010;
            end
            2'd2: begin
                owner_req   = req[2];
                owner_rw    = req_rw[2];
                owner_addr  = req_addr[2*ADDR_W +: ADDR_W];
                owner_wdata = req_wdata[2*DATA_W +: DATA_W];
                owner_mask  = 3'b100;
            end
            default: ;
        endcase
    end

    // An access is issued only while granted, the owner is requesting and reset is low.
    assign issue      = (state == GRANT) && owner_req && !reset;
    assign others_req = |(req & ~owner_mask);

    assign ack        = issue ? owner_mask : 3'b000;
    assign dma_enable = issue;
    assign dma_rw     = issue & owner_rw;
    assign dma_addr   = issue ? owner_addr  : '0;
    assign dma_wdata  = issue ? owner_wdata : '0;

    // Registered outputs are also masked by reset so they read zero during the
    // very first reset cycle, before the synchronous clear has taken effect.
    assign gnt    = reset ? 3'b000 : gnt_q;
    assign rvalid = reset ? 3'b000 : rvalid_q;
    assign rdata  = reset ? '0     : dma_rdata;

    // Arbitration FSM, grant register, burst counter and read-valid pipeline.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            gnt_q      <= 3'b000;
            rvalid_q   <= 3'b000;
`ifdef DMA_ARB_BURST_LIMIT_EN
            burst_cnt  <= 8'd0;
`endif
        end else begin
            // Write acks carry no return data, so only read acks raise rvalid.
            rvalid_q <= ack & {3{~owner_rw}};
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= winner;
                        gnt_q <= 3'b001 << winner;
                        state <= GRANT;
`ifdef DMA_ARB_BURST_LIMIT_EN
                        burst_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state      <= IDLE;
                        gnt_q      <= 3'b000;
                        last_owner <= owner;
                    end
`ifdef DMA_ARB_BURST_LIMIT_EN
                    else if (burst_cnt == BURST_LAST) begin
                        if (others_req) begin
                            state      <= IDLE;
                            gnt_q      <= 3'b000;
                            last_owner <= owner;
                        end
                        burst_cnt <= 8'd0;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed testbench for dma_arbiter with MAX_BURST = 4.
// Burst-limit scenarios run when DMA_ARB_BURST_LIMIT_EN is defined; otherwise
// the hold-until-release scenario runs instead.
module tb_dma_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req;
    logic [2:0]      req_rw;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]      gnt;
    logic [2:0]      ack;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            dma_enable;
    logic            dma_rw;
    logic [AW-1:0]   dma_addr;
    logic [DW-1:0]   dma_wdata;
    logic [DW-1:0]   dma_rdata;

    int checks = 0;
    int errors = 0;

    dma_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .ack        (ack),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .dma_enable (dma_enable),
        .dma_rw     (dma_rw),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rdata  (dma_rdata)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 3'b111; req_rw = 3'b101; dma_rdata = 16'hFFFF;
        set_req(0, 16'h1111, 16'hAAAA);
        set_req(1, 16'h2222, 16'hBBBB);
        set_req(2, 16'h3333, 16'hCCCC);
        cyc(); cyc(); settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b expected %b", gnt, 3'b000); end
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b expected %b", ack, 3'b000); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b expected %b", rvalid, 3'b000); end
        checks++; if (dma_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b expected 0", dma_enable); end
        checks++; if (dma_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b expected 0", dma_rw); end
        checks++; if (dma_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h expected 0000", dma_addr); end
        checks++; if (dma_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h expected 0000", dma_wdata); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h expected 0000", rdata); end
        reset = 1'b0; req = 3'b000; req_rw = 3'b000; dma_rdata = 16'h0000;
        cyc();
    endtask

    // Single read by requester 0: grant, same-cycle ack, rvalid one cycle later.
    task automatic test_single_read();
        req = 3'b001; req_rw = 3'b000; set_req(0, 16'h0005, 16'h0000);
        settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL sr_idle_gnt got %b expected %b", gnt, 3'b000); end
        checks++; if (dma_enable !== 1'b0) begin errors++; $display("FAIL sr_idle_enable got %b expected 0", dma_enable); end
        cyc(); settle();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL sr_gnt got %b expected %b", gnt, 3'b001); end
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL sr_ack got %b expected %b", ack, 3'b001); end
        checks++; if (dma_enable !== 1'b1) begin errors++; $display("FAIL sr_enable got %b expected 1", dma_enable); end
        checks++; if (dma_addr !== 16'h0005) begin errors++; $display("FAIL sr_addr got %h expected 0005", dma_addr); end
        checks++; if (dma_rw !== 1'b0) begin errors++; $display("FAIL sr_rw got %b expected 0", dma_rw); end
        cyc();
        req = 3'b000; dma_rdata = 16'h1234; settle();
        checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL sr_rvalid got %b expected %b", rvalid, 3'b001); end
        checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL sr_rdata got %h expected 1234", rdata); end
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL sr_release_ack got %b expected %b", ack, 3'b000); end
        checks++; if (dma_enable !== 1'b0) begin errors++; $display("FAIL sr_release_enable got %b expected 0", dma_enable); end
        cyc(); dma_rdata = 16'h0000; settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL sr_end_gnt got %b expected %b", gnt, 3'b000); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL sr_end_rvalid got %b expected %b", rvalid, 3'b000); end
    endtask

    // Requester 0 writes; requester 2 rises mid-burst and must not disturb the port.
    task automatic test_preempt();
        req = 3'b001; req_rw = 3'b101;
        set_req(0, 16'h0100, 16'hAAAA);
        set_req(2, 16'h0200, 16'hBBBB);
        cyc(); settle();
        checks++; if (dma_addr !== 16'h0100) begin errors++; $display("FAIL pre_addr0 got %h expected 0100", dma_addr); end
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL pre_ack0 got %b expected %b", ack, 3'b001); end
        cyc();
        req = 3'b101; set_req(0, 16'h0101, 16'hAAAA); settle();
        checks++; if (dma_addr !== 16'h0101) begin errors++; $display("FAIL pre_addr1 got %h expected 0101", dma_addr); end
        checks++; if (dma_wdata !== 16'hAAAA) begin errors++; $display("FAIL pre_wdata got %h expected AAAA", dma_wdata); end
        checks++; if (dma_rw !== 1'b1) begin errors++; $display("FAIL pre_rw got %b expected 1", dma_rw); end
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL pre_gnt got %b expected %b", gnt, 3'b001); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL pre_write_rvalid got %b expected %b", rvalid, 3'b000); end
        cyc();
        set_req(0, 16'h0102, 16'hAAAA); settle();
        checks++; if (dma_addr !== 16'h0102) begin errors++; $display("FAIL pre_addr2 got %h expected 0102", dma_addr); end
        cyc();
        req = 3'b100; settle();
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL pre_release_ack got %b expected %b", ack, 3'b000); end
        cyc(); settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL pre_bubble_gnt got %b expected %b", gnt, 3'b000); end
        checks++; if (dma_enable !== 1'b0) begin errors++; $display("FAIL pre_bubble_enable got %b expected 0", dma_enable); end
        cyc(); settle();
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL pre_gnt2 got %b expected %b", gnt, 3'b100); end
        checks++; if (ack !== 3'b100) begin errors++; $display("FAIL pre_ack2 got %b expected %b", ack, 3'b100); end
        checks++; if (dma_addr !== 16'h0200) begin errors++; $display("FAIL pre_addr_r2 got %h expected 0200", dma_addr); end
        checks++; if (dma_wdata !== 16'hBBBB) begin errors++; $display("FAIL pre_wdata_r2 got %h expected BBBB", dma_wdata); end
        req = 3'b000; req_rw = 3'b000;
        cyc(); cyc();
    endtask

`ifdef DMA_ARB_BURST_LIMIT_EN
    // All three request reads continuously: four acks per grant, one idle cycle between.
    task automatic test_burst_rotate();
        int          order [4] = '{0, 1, 2, 0};
        logic [2:0]  exp;
        logic [2:0]  prev;
        prev = 3'b000;
        req = 3'b111; req_rw = 3'b000;
        for (int k = 0; k < 4; k++) begin
            exp = 3'b001 << order[k];
            settle();
            checks++; if (gnt !== 3'b000 || dma_enable !== 1'b0) begin errors++; $display("FAIL rot_idle[%0d] gnt %b en %b expected 000 0", k, gnt, dma_enable); end
            if (k > 0) begin
                checks++; if (rvalid !== prev) begin errors++; $display("FAIL rot_rvalid[%0d] got %b expected %b", k, rvalid, prev); end
            end
            cyc();
            for (int j = 0; j < 4; j++) begin
                checks++; if (gnt !== exp) begin errors++; $display("FAIL rot_gnt[%0d.%0d] got %b expected %b", k, j, gnt, exp); end
                checks++; if (ack !== exp) begin errors++; $display("FAIL rot_ack[%0d.%0d] got %b expected %b", k, j, ack, exp); end
                cyc();
            end
            prev = exp;
        end
        req = 3'b000; settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rot_end_gnt got %b expected %b", gnt, 3'b000); end
        cyc();
    endtask

    // Lone requester 1 writes 20 times in a row: the limit never breaks the grant.
    task automatic test_long_write();
        req = 3'b010; req_rw = 3'b010;
        cyc();
        for (int i = 0; i < 20; i++) begin
            settle();
            checks++; if (ack !== 3'b010) begin errors++; $display("FAIL lw_ack[%0d] got %b expected %b", i, ack, 3'b010); end
            checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL lw_gnt[%0d] got %b expected %b", i, gnt, 3'b010); end
            checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL lw_rvalid[%0d] got %b expected %b", i, rvalid, 3'b000); end
            cyc();
        end
        req = 3'b000; settle();
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL lw_release_ack got %b expected %b", ack, 3'b000); end
        cyc(); settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL lw_end_gnt got %b expected %b", gnt, 3'b000); end
        req_rw = 3'b000;
    endtask
`else
    // Without a limit, requester 0 keeps the grant while requester 1 waits.
    task automatic test_no_limit();
        req = 3'b011; req_rw = 3'b000;
        cyc();
        for (int i = 0; i < 10; i++) begin
            settle();
            checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL nl_gnt[%0d] got %b expected %b", i, gnt, 3'b001); end
            checks++; if (ack !== 3'b001) begin errors++; $display("FAIL nl_ack[%0d] got %b expected %b", i, ack, 3'b001); end
            cyc();
        end
        req = 3'b010; settle();
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL nl_release_ack got %b expected %b", ack, 3'b000); end
        cyc(); settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL nl_bubble_gnt got %b expected %b", gnt, 3'b000); end
        cyc(); settle();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL nl_gnt1 got %b expected %b", gnt, 3'b010); end
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL nl_ack1 got %b expected %b", ack, 3'b010); end
        req = 3'b000;
        cyc(); cyc();
    endtask
`endif

    // Reset pulse while requester 1 is mid-read; requester 0 must win afterwards.
    task automatic test_reset_mid();
        req = 3'b010; req_rw = 3'b000; set_req(1, 16'h0300, 16'h0000);
        cyc(); settle();
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL rm_ack got %b expected %b", ack, 3'b010); end
        cyc();
        reset = 1'b1; dma_rdata = 16'h5555; settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rm_rst_gnt got %b expected %b", gnt, 3'b000); end
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rm_rst_ack got %b expected %b", ack, 3'b000); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rm_rst_rvalid got %b expected %b", rvalid, 3'b000); end
        checks++; if (dma_enable !== 1'b0 || dma_addr !== 16'h0000) begin errors++; $display("FAIL rm_rst_port en %b addr %h expected 0 0000", dma_enable, dma_addr); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rm_rst_rdata got %h expected 0000", rdata); end
        cyc();
        reset = 1'b0; req = 3'b011; dma_rdata = 16'h0000; settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rm_after_gnt got %b expected %b", gnt, 3'b000); end
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rm_after_ack got %b expected %b", ack, 3'b000); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rm_after_rvalid got %b expected %b", rvalid, 3'b000); end
        checks++; if (dma_enable !== 1'b0) begin errors++; $display("FAIL rm_after_enable got %b expected 0", dma_enable); end
        cyc(); settle();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rm_win_gnt got %b expected %b", gnt, 3'b001); end
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL rm_win_ack got %b expected %b", ack, 3'b001); end
        req = 3'b000;
        cyc(); cyc();
    endtask

    initial begin
        req = 3'b000; req_rw = 3'b000; req_addr = '0; req_wdata = '0;
        dma_rdata = '0; reset = 1'b1;
        test_reset();
        test_single_read();
        test_preempt();
`ifdef DMA_ARB_BURST_LIMIT_EN
        test_burst_rotate();
        test_long_write();
`else
        test_no_limit();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
